mul_7: RTL and testbench

Bit-serial multiply-by-7-and-add block: it rebuilds a 16-bit dividend from a 14-bit quotient and a 4-bit remainder, computing data = q*7 + reminder. It is the inverse of the team's divide-by-7 engine. It sits beside that engine in the datapath, where it reconstructs operands and self-checks divider results. It uses the same start/busy/valid single-shot handshake and processes one quotient bit per cycle, MSB first.

---
 rtl/div7_pkg.sv | 23 ++
 rtl/mul_7_if.sv | 30 +++
 rtl/mul_7.sv | 118 +++++++++++
 tb/tb_mul_7.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/div7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div7_pkg
//  Brief    : Shared constants and FSM encoding for the divide-by-7 engine
//             and its multiply-by-7-and-add inverse.
//  Revision : 1.0  initial release
// ============================================================================
package div7_pkg;

    localparam int DIVISOR = 7;
    localparam int Q_W     = 14;
    localparam int R_W     = 4;
    localparam int D_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_7_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_7_if
//  Brief    : start/busy/valid single-shot handshake bundle for mul_7.
//  Revision : 1.0  initial release
// ============================================================================
interface mul_7_if;
    import div7_pkg::*;

    logic             start;
    logic [Q_W-1:0]   q;
    logic [R_W-1:0]   reminder;
    logic             valid;
    logic             busy;
    logic [D_W-1:0]   data;
    logic             ovf;
    logic             rem_err;

    modport master (
        output start, q, reminder,
        input  valid, busy, data, ovf, rem_err
    );

    modport slave (
        input  start, q, reminder,
        output valid, busy, data, ovf, rem_err
    );

endinterface
`default_nettype wire

// File: rtl/mul_7.sv
`default_nettype none
// ============================================================================
//  Module   : mul_7
//  Brief    : Bit-serial data = q*7 + reminder, one quotient bit per cycle,
//             MSB first; inverse of the divide-by-7 engine.
//  Revision : 1.0  initial release
// ============================================================================
module mul_7
    import div7_pkg::*;
#(
    parameter int DIVISOR = div7_pkg::DIVISOR,
    parameter int Q_W     = div7_pkg::Q_W,
    parameter int R_W     = div7_pkg::R_W,
    parameter int D_W     = div7_pkg::D_W
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    mul_7_if.slave      bus
);

    localparam int              ACC_W = D_W + 1;
    localparam int              CNT_W = $clog2(Q_W);
    localparam logic [CNT_W-1:0] c_MSB = CNT_W'(Q_W - 1);

    state_t             r_state;
    state_t             w_next;

    logic [Q_W-1:0]     r_q;
    logic [R_W-1:0]     r_rem;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_valid;
    logic               r_busy;
    logic [D_W-1:0]     r_data;
    logic               r_ovf;
    logic               r_rem_err;

    logic [ACC_W-1:0]   w_step;
    logic [ACC_W-1:0]   w_sum;

    // acc peaks at 16383*7 + 15, so ACC_W bits never overflow
    assign w_step = {r_acc[ACC_W-2:0], 1'b0}
                  + (r_q[r_bit_cnt] ? ACC_W'(DIVISOR) : {ACC_W{1'b0}});
    assign w_sum  = r_acc + ACC_W'(r_rem);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = bus.start ? RUN : IDLE;
            RUN:     w_next = (r_bit_cnt == '0) ? ADD : RUN;
            ADD:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            r_rem     <= '0;
            r_acc     <= '0;
            r_bit_cnt <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_data    <= '0;
            r_ovf     <= 1'b0;
            r_rem_err <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_q       <= bus.q;
                        r_rem     <= bus.reminder;
                        r_acc     <= '0;
                        r_bit_cnt <= c_MSB;
                        r_busy    <= 1'b1;
                        r_data    <= '0;
                        r_ovf     <= 1'b0;
                        r_rem_err <= 1'b0;
                    end
                end
                RUN: begin
                    r_acc <= w_step;
                    if (r_bit_cnt != '0) begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end
                ADD: begin
                    // full remainder is summed even when it is out of range
                    r_data    <= w_sum[D_W-1:0];
                    r_ovf     <= w_sum[D_W];
                    r_rem_err <= (r_rem >= R_W'(DIVISOR));
                    r_valid   <= 1'b1;
                    r_busy    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.valid   = r_valid;
    assign bus.busy    = r_busy;
    assign bus.data    = r_data;
    assign bus.ovf     = r_ovf;
    assign bus.rem_err = r_rem_err;

endmodule
`default_nettype wire

// File: tb/tb_mul_7.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_7
//  Brief    : Directed, table-driven self-checking bench for mul_7.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_7;
    import div7_pkg::*;

    logic clk;
    logic rst_n;

    mul_7_if bus ();

    mul_7 #(
        .DIVISOR (7),
        .Q_W     (14),
        .R_W     (4),
        .D_W     (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] q;
        logic [3:0]  rem;
        logic [15:0] data;
        logic        ovf;
        logic        rem_err;
        logic        toggle;
    } vec_t;

    vec_t vecs [7];
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid"},   32'(bus.valid),   32'd0);
        check({name, "_busy"},    32'(bus.busy),    32'd0);
        check({name, "_data"},    32'(bus.data),    32'd0);
        check({name, "_ovf"},     32'(bus.ovf),     32'd0);
        check({name, "_rem_err"}, 32'(bus.rem_err), 32'd0);
    endtask

    task automatic run_op(input vec_t v);
        int  n;
        int  busy_drop;
        bit  got;
        @(negedge clk);
        bus.q        = v.q;
        bus.reminder = v.rem;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("data_cleared",     32'(bus.data), 32'd0);
        n = 0;
        got = 1'b0;
        busy_drop = 0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (v.toggle && n == 3) bus.q = ~v.q;
            if (bus.valid) got = 1'b1;
            else if (!bus.busy) busy_drop++;
        end
        check("valid_latency",   32'(n),            32'd15);
        check("busy_held",       32'(busy_drop),    32'd0);
        check("busy_at_valid",   32'(bus.busy),     32'd0);
        check("data",            32'(bus.data),     32'(v.data));
        check("ovf",             32'(bus.ovf),      32'(v.ovf));
        check("rem_err",         32'(bus.rem_err),  32'(v.rem_err));
        @(posedge clk);
        #1;
        check("valid_single",    32'(bus.valid),    32'd0);
        check("data_hold",       32'(bus.data),     32'(v.data));
    endtask

    initial begin
        int  pulses;
        int  first_at;
        int  second_at;
        int  stray;
        bit  prev_valid;
        bit  back_to_back;
        vec_t v;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{q: 14'd1234,  rem: 4'd5,  data: 16'd8643,  ovf: 1'b0, rem_err: 1'b0, toggle: 1'b0};
        vecs[1] = '{q: 14'd9362,  rem: 4'd2,  data: 16'd0,     ovf: 1'b1, rem_err: 1'b0, toggle: 1'b0};
        vecs[2] = '{q: 14'd9362,  rem: 4'd1,  data: 16'd65535, ovf: 1'b0, rem_err: 1'b0, toggle: 1'b0};
        vecs[3] = '{q: 14'd100,   rem: 4'd9,  data: 16'd709,   ovf: 1'b0, rem_err: 1'b1, toggle: 1'b0};
        vecs[4] = '{q: 14'd0,     rem: 4'd0,  data: 16'd0,     ovf: 1'b0, rem_err: 1'b0, toggle: 1'b0};
        vecs[5] = '{q: 14'd16383, rem: 4'd15, data: 16'd49160, ovf: 1'b1, rem_err: 1'b1, toggle: 1'b0};
        vecs[6] = '{q: 14'd3,     rem: 4'd1,  data: 16'd22,    ovf: 1'b0, rem_err: 1'b0, toggle: 1'b1};

        bus.start    = 1'b0;
        bus.q        = '0;
        bus.reminder = '0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i]);
        end

        // start held high: accepts at E0, E17, E34 -> valids at E15, E32 in a 40-edge window
        @(negedge clk);
        bus.q        = 14'd3;
        bus.reminder = 4'd1;
        bus.start    = 1'b1;
        pulses = 0;
        first_at = -1;
        second_at = -1;
        prev_valid = 1'b0;
        back_to_back = 1'b0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.valid) begin
                if (prev_valid) back_to_back = 1'b1;
                pulses++;
                if (pulses == 1) first_at = e;
                if (pulses == 2) second_at = e;
                check("held_data", 32'(bus.data), 32'd22);
            end
            prev_valid = bus.valid;
        end
        bus.start = 1'b0;
        check("held_pulses",    32'(pulses),            32'd2);
        check("held_first",     32'(first_at),          32'd15);
        check("held_spacing",   32'(second_at - first_at), 32'd17);
        check("held_no_b2b",    32'(back_to_back),      32'd0);
        repeat (25) @(posedge clk);

        // reset asserted during RUN cycle 7
        @(negedge clk);
        bus.q        = 14'd1234;
        bus.reminder = 4'd5;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre_abort_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (bus.valid || bus.busy) stray++;
        end
        check("no_valid_after_abort", 32'(stray), 32'd0);

        v = '{q: 14'd10, rem: 4'd3, data: 16'd73, ovf: 1'b0, rem_err: 1'b0, toggle: 1'b0};
        run_op(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
